// File: rtl/aqua_pkg.sv
// aqua_pkg: shared measurement width and the collector state encoding (db_estado values).
package aqua_pkg;
    localparam int MEDIDA_W = 12;
    typedef enum logic [3:0] {
        ST_OCIOSO        = 4'd0,
        ST_DISPARA       = 4'd1,
        ST_ESPERA        = 4'd2,
        ST_ARMAZENA      = 4'd3,
        ST_INTERVALO     = 4'd4,
        ST_ENTREGA       = 4'd5,
        ST_AGUARDA_CLASS = 4'd6,
        ST_FIM           = 4'd7,
        ST_ERRO          = 4'd8
    } estado_t;
endpackage

// File: rtl/coletor_medidas_contador_sat.sv
// contador_sat: clearable saturating up-counter that flags when it equals a limit.
module contador_sat #(
    parameter int CNT_W = 24
) (
    input  logic             clock,
    input  logic             zera,
    input  logic             limpa_i,
    input  logic [CNT_W-1:0] limite_i,
    output logic             fim_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = limpa_i ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    always_ff @(posedge clock or posedge zera) begin
        if (zera) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign fim_o = cnt_q == limite_i;
endmodule

// File: rtl/coletor_medidas.sv
// coletor_medidas: takes three spaced sensor readings, hands them to the classifier, reports done/timeout.
// Optional COLETOR_REPETE_DESCARTE_EN: repeat the whole sequence when the classifier asks to discard it.
module coletor_medidas
    import aqua_pkg::*;
#(
    parameter int TIMEOUT_CICLOS   = 1000000,
    parameter int INTERVALO_CICLOS = 50000,
    parameter int LATENCIA_CLASS   = 3,
    parameter int CNT_W            = 24
`ifdef COLETOR_REPETE_DESCARTE_EN
    , parameter int MAX_REPETICOES = 2
`endif
) (
    input  logic                clock,
    input  logic                zera,
    input  logic                medir,
    input  logic                pronto_sensor,
    input  logic [MEDIDA_W-1:0] dado_sensor,
    input  logic                fim_classificacao,
`ifdef COLETOR_REPETE_DESCARTE_EN
    input  logic                descartar_medida,
`endif
    output logic                inicia_sensor,
    output logic [MEDIDA_W-1:0] medida1,
    output logic [MEDIDA_W-1:0] medida2,
    output logic [MEDIDA_W-1:0] medida3,
    output logic                iniciar,
    output logic                ocupado,
    output logic                pronto,
    output logic                erro_timeout,
    output logic [3:0]          db_estado
);
    estado_t             estado_q, estado_d;
    logic [1:0]          idx_q, idx_d;
    logic [MEDIDA_W-1:0] med_q [3];
    logic [MEDIDA_W-1:0] med_d [3];
    logic                pronto_q, pronto_d, erro_q, erro_d, ocupado_q, fim_prev_q;
    logic                limpa, fim_cnt;
    logic [CNT_W-1:0]    limite;
`ifdef COLETOR_REPETE_DESCARTE_EN
    logic [7:0]          rep_q, rep_d;
`endif

    // One counter serves timeout, interval and classifier latency; only one is live per state.
    assign limpa  = estado_q inside {ST_DISPARA, ST_ARMAZENA, ST_ENTREGA};
    assign limite = (estado_q == ST_ESPERA)    ? CNT_W'(TIMEOUT_CICLOS - 1) :
                    (estado_q == ST_INTERVALO) ? CNT_W'(INTERVALO_CICLOS - 1) :
                                                 CNT_W'(LATENCIA_CLASS - 1);

    contador_sat #(.CNT_W(CNT_W)) u_cnt (
        .clock    (clock),
        .zera     (zera),
        .limpa_i  (limpa),
        .limite_i (limite),
        .fim_o    (fim_cnt)
    );

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        med_d    = med_q;
        pronto_d = pronto_q;
        erro_d   = erro_q;
`ifdef COLETOR_REPETE_DESCARTE_EN
        rep_d    = rep_q;
`endif
        case (estado_q)
            ST_OCIOSO, ST_FIM, ST_ERRO: if (medir) begin
                pronto_d = 1'b0;
                erro_d   = 1'b0;
                idx_d    = '0;
`ifdef COLETOR_REPETE_DESCARTE_EN
                rep_d    = '0;
`endif
                estado_d = ST_DISPARA;
            end
            ST_DISPARA:   estado_d = ST_ESPERA;
            ST_ESPERA: if (pronto_sensor) begin
                med_d[idx_q] = dado_sensor;
                estado_d     = ST_ARMAZENA;
            end else if (fim_cnt) begin
                erro_d   = 1'b1;
                estado_d = ST_ERRO;
            end
            ST_ARMAZENA: begin
                idx_d    = (idx_q == 2'd2) ? idx_q : idx_q + 1'b1;
                estado_d = (idx_q == 2'd2) ? ST_ENTREGA : ST_INTERVALO;
            end
            ST_INTERVALO: estado_d = fim_cnt ? ST_DISPARA : ST_INTERVALO;
            ST_ENTREGA:   estado_d = ST_AGUARDA_CLASS;
            ST_AGUARDA_CLASS: if ((fim_classificacao && !fim_prev_q) || fim_cnt) begin
`ifdef COLETOR_REPETE_DESCARTE_EN
                if (descartar_medida && rep_q < 8'(MAX_REPETICOES)) begin
                    rep_d    = rep_q + 1'b1;
                    idx_d    = '0;
                    estado_d = ST_DISPARA;
                end else begin
                    pronto_d = 1'b1;
                    estado_d = ST_FIM;
                end
`else
                pronto_d = 1'b1;
                estado_d = ST_FIM;
`endif
            end
            default:      estado_d = ST_OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge zera) begin
        if (zera) begin
            estado_q   <= ST_OCIOSO;
            idx_q      <= '0;
            med_q      <= '{default: '0};
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            fim_prev_q <= 1'b0;
`ifdef COLETOR_REPETE_DESCARTE_EN
            rep_q      <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            med_q      <= med_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
            ocupado_q  <= !(estado_d inside {ST_OCIOSO, ST_FIM, ST_ERRO});
            fim_prev_q <= fim_classificacao;
`ifdef COLETOR_REPETE_DESCARTE_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign inicia_sensor = estado_q == ST_DISPARA;
    assign iniciar       = estado_q == ST_ENTREGA;
    assign medida1       = med_q[0];
    assign medida2       = med_q[1];
    assign medida3       = med_q[2];
    assign ocupado       = ocupado_q;
    assign pronto        = pronto_q;
    assign erro_timeout  = erro_q;
    assign db_estado     = estado_q;
endmodule

// File: tb/tb_coletor_medidas.sv
// tb_coletor_medidas: directed scenarios for coletor_medidas with a scripted sensor model.
module tb_coletor_medidas;
    logic        clock = 1'b0;
    logic        zera = 1'b1;
    logic        medir = 1'b0;
    logic        pronto_sensor = 1'b0;
    logic [11:0] dado_sensor = '0;
    logic        fim_classificacao = 1'b0;
`ifdef COLETOR_REPETE_DESCARTE_EN
    logic        descartar_medida = 1'b0;
`endif
    logic        inicia_sensor, iniciar, ocupado, pronto, erro_timeout;
    logic [11:0] medida1, medida2, medida3;
    logic [3:0]  db_estado;

    int checks = 0, fails = 0;
    int n_trig = 0, trig_base = 0, n_resp = 0, resp_delay = 5, wait_cnt = 0, n_ini = 0;
    logic [11:0] dados [4];
    logic [11:0] cur = '0;

    coletor_medidas #(
        .TIMEOUT_CICLOS(20), .INTERVALO_CICLOS(4), .LATENCIA_CLASS(3), .CNT_W(24)
    ) dut (
        .clock(clock), .zera(zera), .medir(medir), .pronto_sensor(pronto_sensor),
        .dado_sensor(dado_sensor), .fim_classificacao(fim_classificacao),
`ifdef COLETOR_REPETE_DESCARTE_EN
        .descartar_medida(descartar_medida),
`endif
        .inicia_sensor(inicia_sensor), .medida1(medida1), .medida2(medida2), .medida3(medida3),
        .iniciar(iniciar), .ocupado(ocupado), .pronto(pronto), .erro_timeout(erro_timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Sensor answers the first n_resp triggers after trig_base, resp_delay cycles after each.
    always @(negedge clock) begin
        pronto_sensor = 1'b0;
        if (wait_cnt > 0) begin
            wait_cnt = wait_cnt - 1;
            if (wait_cnt == 0) begin
                pronto_sensor = 1'b1;
                dado_sensor   = cur;
            end
        end
        if (inicia_sensor === 1'b1) begin
            n_trig = n_trig + 1;
            if (n_trig - trig_base <= n_resp) begin
                wait_cnt = resp_delay;
                cur      = dados[(n_trig - trig_base - 1) % 4];
            end
        end
    end

    always @(negedge clock) if (iniciar === 1'b1) n_ini = n_ini + 1;

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 4'd0) begin fails++; $display("FAIL rst_estado: got %0d expected 0", db_estado); end
        checks++; if ({inicia_sensor, iniciar, ocupado, pronto, erro_timeout} !== 5'b0) begin fails++; $display("FAIL rst_flags: got %b expected 00000", {inicia_sensor, iniciar, ocupado, pronto, erro_timeout}); end
        checks++; if ({medida1, medida2, medida3} !== 36'h0) begin fails++; $display("FAIL rst_medidas: got %h expected 0", {medida1, medida2, medida3}); end
        zera = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (n_trig !== 0 || db_estado !== 4'd0) begin fails++; $display("FAIL rst_idle: got trig=%0d estado=%0d expected 0/0", n_trig, db_estado); end
    endtask

    task automatic test_nominal();
        int t, nt, na, t_ini, ini0;
        int t_trig [3];
        int t_arm [3];
        trig_base = n_trig; n_resp = 3; resp_delay = 5; ini0 = n_ini;
        dados[0] = 12'h100; dados[1] = 12'h102; dados[2] = 12'h101;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        checks++; if (ocupado !== 1'b1) begin fails++; $display("FAIL nom_ocupado_run: got %b expected 1", ocupado); end
        t = 0; nt = 0; na = 0; t_ini = -100;
        while (t < 300 && db_estado !== 4'd7) begin
            if (inicia_sensor === 1'b1 && nt < 3) begin t_trig[nt] = t; nt++; end
            if (db_estado === 4'd3 && na < 3) begin t_arm[na] = t; na++; end
            if (iniciar === 1'b1) t_ini = t;
            @(negedge clock); t++;
        end
        checks++; if (db_estado !== 4'd7) begin fails++; $display("FAIL nom_reach_fim: got estado %0d expected 7", db_estado); end
        checks++; if (n_trig - trig_base !== 3) begin fails++; $display("FAIL nom_triggers: got %0d expected 3", n_trig - trig_base); end
        checks++; if (t_trig[1] - t_arm[0] - 1 !== 4) begin fails++; $display("FAIL nom_gap1: got %0d idle cycles expected 4", t_trig[1] - t_arm[0] - 1); end
        checks++; if (t_trig[2] - t_arm[1] - 1 !== 4) begin fails++; $display("FAIL nom_gap2: got %0d idle cycles expected 4", t_trig[2] - t_arm[1] - 1); end
        checks++; if (t - t_ini !== 4) begin fails++; $display("FAIL nom_latency: got %0d expected 4", t - t_ini); end
        checks++; if ({medida1, medida2, medida3} !== {12'h100, 12'h102, 12'h101}) begin fails++; $display("FAIL nom_medidas: got %h %h %h expected 100 102 101", medida1, medida2, medida3); end
        checks++; if (n_ini - ini0 !== 1) begin fails++; $display("FAIL nom_iniciar: got %0d expected 1", n_ini - ini0); end
        checks++; if ({pronto, ocupado, erro_timeout} !== 3'b100) begin fails++; $display("FAIL nom_status: got %b expected 100", {pronto, ocupado, erro_timeout}); end
    endtask

    task automatic test_timeout();
        int t, nt, t2, ini0;
        trig_base = n_trig; n_resp = 1; resp_delay = 5; ini0 = n_ini;
        dados[0] = 12'h2AB;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        t = 0; nt = 0; t2 = -100;
        while (t < 300 && erro_timeout !== 1'b1) begin
            if (inicia_sensor === 1'b1) begin nt++; if (nt == 2) t2 = t; end
            @(negedge clock); t++;
        end
        checks++; if (erro_timeout !== 1'b1 || db_estado !== 4'd8) begin fails++; $display("FAIL to_erro: got erro=%b estado=%0d expected 1/8", erro_timeout, db_estado); end
        checks++; if (t - t2 - 1 !== 20) begin fails++; $display("FAIL to_wait: got %0d cycles expected 20", t - t2 - 1); end
        checks++; if (nt !== 2) begin fails++; $display("FAIL to_triggers: got %0d expected 2", nt); end
        checks++; if (medida1 !== 12'h2AB || medida2 !== 12'h102) begin fails++; $display("FAIL to_partial: got %h %h expected 2ab 102", medida1, medida2); end
        checks++; if (n_ini !== ini0) begin fails++; $display("FAIL to_iniciar: got %0d expected 0", n_ini - ini0); end
        checks++; if ({pronto, ocupado} !== 2'b00) begin fails++; $display("FAIL to_status: got %b expected 00", {pronto, ocupado}); end
        trig_base = n_trig; n_resp = 3;
        dados[0] = 12'h010; dados[1] = 12'h020; dados[2] = 12'h030;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        checks++; if (erro_timeout !== 1'b0 || db_estado !== 4'd1) begin fails++; $display("FAIL to_restart: got erro=%b estado=%0d expected 0/1", erro_timeout, db_estado); end
        t = 0;
        while (t < 300 && db_estado !== 4'd7) begin @(negedge clock); t++; end
        checks++; if (pronto !== 1'b1 || medida3 !== 12'h030) begin fails++; $display("FAIL to_rerun: got pronto=%b m3=%h expected 1/030", pronto, medida3); end
    endtask

    task automatic test_tie();
        int t, t_ini;
        bit seen_erro;
        trig_base = n_trig; n_resp = 3; resp_delay = 20;
        dados[0] = 12'h7FF; dados[1] = 12'h800; dados[2] = 12'hFFF;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        t = 0; t_ini = -100; seen_erro = 0;
        while (t < 300 && db_estado !== 4'd7) begin
            if (db_estado === 4'd8) seen_erro = 1;
            if (iniciar === 1'b1) t_ini = t;
            if (db_estado === 4'd6) fim_classificacao = 1'b1;
            @(negedge clock); t++;
        end
        checks++; if (seen_erro || erro_timeout !== 1'b0 || pronto !== 1'b1) begin fails++; $display("FAIL tie_no_erro: got seen=%0d erro=%b pronto=%b expected 0/0/1", seen_erro, erro_timeout, pronto); end
        checks++; if ({medida1, medida2, medida3} !== {12'h7FF, 12'h800, 12'hFFF}) begin fails++; $display("FAIL tie_medidas: got %h %h %h expected 7ff 800 fff", medida1, medida2, medida3); end
        checks++; if (t - t_ini !== 2) begin fails++; $display("FAIL tie_fim_edge: got %0d expected 2", t - t_ini); end
    endtask

    task automatic test_back_to_back();
        int t, ini0;
        trig_base = n_trig; n_resp = 6; resp_delay = 3; ini0 = n_ini;
        dados[0] = 12'h0A5; dados[1] = 12'h0B6; dados[2] = 12'h0C7; dados[3] = 12'h0D8;
        medir = 1'b1; @(negedge clock);
        t = 0;
        while (t < 300 && db_estado !== 4'd7) begin @(negedge clock); t++; end
        checks++; if (n_trig - trig_base !== 3 || pronto !== 1'b1) begin fails++; $display("FAIL b2b_first: got trig=%0d pronto=%b expected 3/1", n_trig - trig_base, pronto); end
        @(negedge clock); medir = 1'b0;
        checks++; if ({db_estado, pronto, ocupado} !== {4'd1, 1'b0, 1'b1}) begin fails++; $display("FAIL b2b_restart: got estado=%0d pronto=%b ocupado=%b expected 1/0/1", db_estado, pronto, ocupado); end
        t = 0;
        while (t < 300 && db_estado !== 4'd7) begin @(negedge clock); t++; end
        checks++; if (n_trig - trig_base !== 6 || n_ini - ini0 !== 2) begin fails++; $display("FAIL b2b_second: got trig=%0d ini=%0d expected 6/2", n_trig - trig_base, n_ini - ini0); end
    endtask

    task automatic test_reset_mid();
        int t, base2;
        trig_base = n_trig; n_resp = 0;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        t = 0;
        while (t < 20 && db_estado !== 4'd2) begin @(negedge clock); t++; end
        #2 zera = 1'b1;
        #1;
        checks++; if (db_estado !== 4'd0 || {inicia_sensor, iniciar, ocupado, pronto, erro_timeout} !== 5'b0) begin fails++; $display("FAIL rmid_flags: got estado=%0d flags=%b expected 0/00000", db_estado, {inicia_sensor, iniciar, ocupado, pronto, erro_timeout}); end
        checks++; if ({medida1, medida2, medida3} !== 36'h0) begin fails++; $display("FAIL rmid_medidas: got %h expected 0", {medida1, medida2, medida3}); end
        @(negedge clock); zera = 1'b0;
        base2 = n_trig;
        repeat (30) @(negedge clock);
        checks++; if (n_trig !== base2 || db_estado !== 4'd0) begin fails++; $display("FAIL rmid_quiet: got trig=%0d estado=%0d expected 0/0", n_trig - base2, db_estado); end
    endtask

`ifdef COLETOR_REPETE_DESCARTE_EN
    task automatic test_repete();
        int t, ini0;
        trig_base = n_trig; n_resp = 9; resp_delay = 3; ini0 = n_ini;
        descartar_medida = 1'b1;
        medir = 1'b1; @(negedge clock); medir = 1'b0;
        t = 0;
        while (t < 1000 && db_estado !== 4'd7) begin @(negedge clock); t++; end
        checks++; if (n_trig - trig_base !== 9 || n_ini - ini0 !== 3 || pronto !== 1'b1) begin fails++; $display("FAIL rep_count: got trig=%0d ini=%0d pronto=%b expected 9/3/1", n_trig - trig_base, n_ini - ini0, pronto); end
        descartar_medida = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_tie();
        test_back_to_back();
        test_reset_mid();
`ifdef COLETOR_REPETE_DESCARTE_EN
        test_repete();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
